imem_uart_loader: RTL and testbench
===================================

// Module: imem_uart_loader
// PURPOSE
//  Writer side of the instruction memory: receives a program image byte-by-byte from the UART
//  receiver, assembles 32-bit little-endian words and writes them into the instruction RAM that
//  the single-cycle CPU fetches from. Holds the CPU in reset until a complete, checksum-valid
//  image has been written. Sits between the UART RX core and the imem write port.
// PARAMETERS
//  MEM_WORDS       150      instruction memory depth in 32-bit words; max accepted word count
//  TIMEOUT_CYCLES  1000000  idle clocks between bytes inside a frame before abort
//  MAGIC           8'hA5    frame start byte
// PORTS
//  clk        in   1   system clock, single clock domain
//  reset      in   1   asynchronous, active-high reset
//  rx_data    in   8   byte from UART receiver
//  rx_valid   in   1   one-cycle strobe, rx_data valid
//  wr_en      out  1   imem write strobe, one cycle per word
//  wr_addr    out  31  imem byte address, word aligned (word_index<<2)
//  wr_data    out  32  imem write data
//  cpu_hold   out  1   1 = keep CPU in reset
//  load_done  out  1   image loaded and verified (sticky)
//  load_err   out  1   last frame aborted (sticky until next MAGIC)
// BEHAVIOUR
//  - Reset values: wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, load_done=0, load_err=0, state=IDLE.
//  - Frame: MAGIC, LEN_LO, LEN_HI (16-bit word count N), 4*N data bytes (LSB first), CSUM.
//    CSUM = 8-bit sum mod 256 of all 4*N data bytes.
//  - States: IDLE -> LEN_LO -> LEN_HI -> DATA -> CSUM -> DONE; ERROR from any frame state.
//    IDLE: rx_valid && rx_data==MAGIC -> LEN_LO; other bytes ignored.
//    LEN_HI: N>MEM_WORDS -> ERROR; N==0 -> CSUM; else DATA, word_index=0, byte_cnt=0, sum=0.
//    DATA: each byte shifts into word[8*byte_cnt +: 8], sum+=byte; on 4th byte wr_en pulses the
//      following cycle with wr_addr=word_index<<2, wr_data=assembled word; word_index++;
//      after word N-1 -> CSUM.
//    CSUM: byte==sum -> DONE; mismatch -> ERROR.
//    DONE: cpu_hold=0, load_done=1; all further bytes ignored until reset.
//    ERROR: load_err=1, cpu_hold=1; a MAGIC byte clears load_err and enters LEN_LO.
//  - Timeout: counter clears on each rx_valid; in LEN_LO/LEN_HI/DATA/CSUM reaching
//    TIMEOUT_CYCLES-1 -> ERROR. Not active in IDLE/DONE/ERROR.
//  - At most one write per 4 rx_valid strobes; wr_en never asserted outside DATA->write cycle.
//  - rx_valid on consecutive cycles must be accepted without loss (latency 1 to wr_en).
//  - Words written before an ERROR remain in RAM; the CPU stays held, so they are never fetched.
//  - Reset mid-frame: immediate return to IDLE, all counters/sum cleared, cpu_hold=1.
//  - word_index width $clog2(MEM_WORDS+1); byte_cnt 2 bits wraps 3->0; sum wraps mod 256.
// STRUCTURE
//  - Package imem_loader_pkg: state enum (IDLE,LEN_LO,LEN_HI,DATA,CSUM,DONE,ERROR), MAGIC default,
//    frame field widths.
//  - One sub-module: byte_word_packer (4-byte LE shift/assemble, word_ready pulse); FSM, timeout
//    counter and checksum stay in the top.
// TESTING
//  - Reset then frame A5 02 00 | 01 00 00 00 | 78 56 34 12 | CSUM=0x15 -> writes (0x0,0x00000001),
//    (0x4,0x12345678); load_done=1, cpu_hold=0.
//  - Same frame with CSUM=0x16 -> both writes occur, load_err=1, cpu_hold=1; resend good frame ->
//    load_err=0, load_done=1.
//  - A5 97 00 (N=151 > MEM_WORDS) -> ERROR, zero writes.
//  - A5 01 00 then 2 data bytes, then silence TIMEOUT_CYCLES -> load_err=1; bytes 00 A5 sent in
//    IDLE-before-frame ignored except A5.
//  - Back-to-back rx_valid every cycle for N=3 frame -> exactly 3 wr_en pulses, addresses 0,4,8.
//  - reset asserted during DATA byte 2 -> all outputs to reset values same cycle; new frame loads cleanly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: FSM state codes, frame field widths
// and the default frame start byte.
package imem_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StLenLo = 3'd1;
  localparam state_t StLenHi = 3'd2;
  localparam state_t StData  = 3'd3;
  localparam state_t StCsum  = 3'd4;
  localparam state_t StDone  = 3'd5;
  localparam state_t StError = 3'd6;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 31;

endpackage

// File: rtl/imem_uart_loader_packer.sv
// Assembles four bytes (least significant first) into a 32-bit word and emits a one-cycle
// word_ready pulse, registered, on the cycle after the fourth byte.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_last_o,
  output logic              word_ready_o,
  output logic [WORD_W-1:0] word_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              ready_q, ready_d;

  assign word_last_o = byte_valid_i && (cnt_q == 2'd3);

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    ready_d = word_last_o;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    shift_d[7:0]   = byte_i;
        2'd1:    shift_d[15:8]  = byte_i;
        2'd2:    shift_d[23:16] = byte_i;
        default: word_d         = {byte_i, shift_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      ready_q <= ready_d;
    end
  end

  assign word_ready_o = ready_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Receives a framed program image from the UART, writes it word by word into instruction RAM and
// releases the CPU only once the whole image has arrived with a matching checksum.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS      = 150,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              pack_valid, pack_clear, word_last, in_frame;

  byte_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (pack_clear),
    .byte_valid_i (pack_valid),
    .byte_i       (rx_data),
    .word_last_o  (word_last),
    .word_ready_o (wr_en),
    .word_o       (wr_data)
  );

  assign in_frame = (state_q == StLenLo) || (state_q == StLenHi) ||
                    (state_q == StData)  || (state_q == StCsum);

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    wr_addr_d  = wr_addr_q;
    pack_valid = 1'b0;
    pack_clear = 1'b0;
    tmr_d      = (!in_frame || rx_valid) ? '0 : tmr_q + TmrW'(1);

    case (state_q)
      StIdle, StError: begin
        if (rx_valid && rx_data == MAGIC) state_d = StLenLo;
      end
      StLenLo: begin
        if (rx_valid) begin
          len_lo_d = rx_data;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (rx_valid) begin
          len_d      = {rx_data, len_lo_q};
          idx_d      = '0;
          sum_d      = 8'd0;
          pack_clear = 1'b1;
          if (32'(len_d) > MEM_WORDS)  state_d = StError;
          else if (len_d == '0)        state_d = StCsum;
          else                         state_d = StData;
        end
      end
      StData: begin
        if (rx_valid) begin
          pack_valid = 1'b1;
          sum_d      = sum_q + rx_data;
          if (word_last) begin
            idx_d     = idx_q + IdxW'(1);
            wr_addr_d = ADDR_W'({idx_q, 2'b00});
            if (32'(idx_q) + 32'd1 == 32'(len_q)) state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (rx_valid) state_d = (rx_data == sum_q) ? StDone : StError;
      end
      StDone: ;
      default: state_d = StIdle;
    endcase

    // A stalled sender aborts the frame; the counter only runs between bytes of a frame.
    if (in_frame && !rx_valid && tmr_q == TmrW'(TIMEOUT_CYCLES - 1)) state_d = StError;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      len_lo_q  <= 8'd0;
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= 8'd0;
      tmr_q     <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      tmr_q     <= tmr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign wr_addr   = wr_addr_q;
  assign cpu_hold  = (state_q != StDone);
  assign load_done = (state_q == StDone);
  assign load_err  = (state_q == StError);

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomised self-checking bench for imem_uart_loader against a frame-level reference model.
module tb_imem_uart_loader;

  localparam int MW = 150;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        wr_en;
  logic [30:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold, load_done, load_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [30:0] cap_a[$];
  logic [31:0] cap_d[$];
  logic [30:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [7:0]  dq[$];
  logic        exp_done, exp_err;

  always #5 clk = ~clk;

  imem_uart_loader #(
    .MEM_WORDS      (MW),
    .TIMEOUT_CYCLES (TO),
    .MAGIC          (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always @(negedge clk) begin
    if (!reset && wr_en) begin
      cap_a.push_back(wr_addr);
      cap_d.push_back(wr_data);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
  endtask

  task automatic gap(input int max_gap);
    idle(int'($urandom_range(max_gap, 0)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    cap_a.delete();
    cap_d.delete();
    reset = 1'b0;
  endtask

  task automatic fill_data(input int n);
    dq.delete();
    for (int i = 0; i < 4 * n; i++) dq.push_back(8'($urandom));
  endtask

  function automatic logic [7:0] good_csum();
    int s = 0;
    foreach (dq[i]) s += int'(dq[i]);
    return 8'(s % 256);
  endfunction

  task automatic send_frame(input int n, input logic [7:0] csum, input int max_gap,
                            input bit hdr_only);
    drive_byte(8'hA5);  gap(max_gap);
    drive_byte(n[7:0]); gap(max_gap);
    drive_byte(n[15:8]);
    if (!hdr_only) begin
      foreach (dq[i]) begin
        gap(max_gap);
        drive_byte(dq[i]);
      end
      gap(max_gap);
      drive_byte(csum);
    end
    idle(4);
  endtask

  // Frame-level expectation: each word is written at 4*i; status depends only on length and sum.
  task automatic model_frame(input int n, input logic [7:0] csum);
    exp_a.delete();
    exp_d.delete();
    if (n > MW) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(31'(4 * i));
      exp_d.push_back({dq[4*i+3], dq[4*i+2], dq[4*i+1], dq[4*i]});
    end
    exp_done = (csum == good_csum());
    exp_err  = !exp_done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 6;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset wr_en: got %b expected 0", wr_en); end
    if (wr_addr !== 31'd0) begin n_fail++; $display("FAIL reset wr_addr: got %h expected 0", wr_addr); end
    if (wr_data !== 32'd0) begin n_fail++; $display("FAIL reset wr_data: got %h expected 0", wr_data); end
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset cpu_hold: got %b expected 1", cpu_hold); end
    if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset load_done: got %b expected 0", load_done); end
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset load_err: got %b expected 0", load_err); end
    reset = 1'b0;
  endtask

  task automatic test_good_frame();
    do_reset();
    dq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_frame(2, 8'h15, 1, 1'b0);
    exp_a = '{31'h0, 31'h4};
    exp_d = '{32'h00000001, 32'h12345678};
    // A later frame after DONE must be ignored entirely.
    send_frame(2, 8'h15, 0, 1'b0);
    n_checks++;
    if (cap_a.size() != 2) begin n_fail++; $display("FAIL good write count: got %0d expected 2", cap_a.size()); end
    foreach (exp_a[i]) if (i < cap_a.size()) begin
      n_checks++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL good write %0d: got %h/%h expected %h/%h", i, cap_a[i], cap_d[i], exp_a[i], exp_d[i]);
      end
    end
    n_checks += 3;
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL good load_done: got %b expected 1", load_done); end
    if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL good cpu_hold: got %b expected 0", cpu_hold); end
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL good load_err: got %b expected 0", load_err); end
  endtask

  task automatic test_bad_csum();
    do_reset();
    dq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_frame(2, 8'h16, 0, 1'b0);
    n_checks += 4;
    if (cap_a.size() != 2) begin n_fail++; $display("FAIL badcsum write count: got %0d expected 2", cap_a.size()); end
    if (load_err !== 1'b1) begin n_fail++; $display("FAIL badcsum load_err: got %b expected 1", load_err); end
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL badcsum cpu_hold: got %b expected 1", cpu_hold); end
    if (load_done !== 1'b0) begin n_fail++; $display("FAIL badcsum load_done: got %b expected 0", load_done); end
    send_frame(2, 8'h15, 2, 1'b0);
    n_checks += 3;
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL resend load_err: got %b expected 0", load_err); end
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL resend load_done: got %b expected 1", load_done); end
    if (cap_a.size() != 4) begin n_fail++; $display("FAIL resend write count: got %0d expected 4", cap_a.size()); end
  endtask

  task automatic test_too_long();
    do_reset();
    dq.delete();
    send_frame(151, 8'h00, 0, 1'b1);
    n_checks += 3;
    if (load_err !== 1'b1) begin n_fail++; $display("FAIL toolong load_err: got %b expected 1", load_err); end
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL toolong cpu_hold: got %b expected 1", cpu_hold); end
    if (cap_a.size() != 0) begin n_fail++; $display("FAIL toolong write count: got %0d expected 0", cap_a.size()); end
  endtask

  task automatic test_timeout();
    int waited = 0;
    do_reset();
    drive_byte(8'h00);
    drive_byte(8'h37);
    idle(2);
    drive_byte(8'hA5);
    drive_byte(8'h01);
    drive_byte(8'h00);
    drive_byte(8'h11);
    drive_byte(8'h22);
    idle(TO / 2);
    n_checks++;
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL timeout early load_err: got %b expected 0", load_err); end
    while (load_err !== 1'b1 && waited < TO + 10) begin
      idle(1);
      waited++;
    end
    waited += TO / 2;
    n_checks += 4;
    if (load_err !== 1'b1) begin n_fail++; $display("FAIL timeout load_err: got %b expected 1", load_err); end
    if (waited < TO - 2 || waited > TO + 2) begin
      n_fail++; $display("FAIL timeout latency: got %0d expected %0d..%0d", waited, TO - 2, TO + 2);
    end
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL timeout cpu_hold: got %b expected 1", cpu_hold); end
    if (cap_a.size() != 0) begin n_fail++; $display("FAIL timeout write count: got %0d expected 0", cap_a.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_data(3);
    send_frame(3, good_csum(), 0, 1'b0);
    model_frame(3, good_csum());
    n_checks++;
    if (cap_a.size() != 3) begin n_fail++; $display("FAIL b2b write count: got %0d expected 3", cap_a.size()); end
    foreach (exp_a[i]) if (i < cap_a.size()) begin
      n_checks++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL b2b write %0d: got %h/%h expected %h/%h", i, cap_a[i], cap_d[i], exp_a[i], exp_d[i]);
      end
    end
    n_checks++;
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL b2b load_done: got %b expected 1", load_done); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w0;
    do_reset();
    fill_data(2);
    dq[0] = 8'h5A;
    w0 = {dq[3], dq[2], dq[1], dq[0]};
    drive_byte(8'hA5);
    drive_byte(8'h02);
    drive_byte(8'h00);
    for (int i = 0; i < 6; i++) drive_byte(dq[i]);
    n_checks++;
    if (wr_data !== w0) begin n_fail++; $display("FAIL midreset first word: got %h expected %h", wr_data, w0); end
    @(negedge clk);
    rx_data = dq[6];
    rx_valid = 1'b1;
    reset = 1'b1;
    #1;
    n_checks += 6;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL midreset wr_en: got %b expected 0", wr_en); end
    if (wr_addr !== 31'd0) begin n_fail++; $display("FAIL midreset wr_addr: got %h expected 0", wr_addr); end
    if (wr_data !== 32'd0) begin n_fail++; $display("FAIL midreset wr_data: got %h expected 0", wr_data); end
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL midreset cpu_hold: got %b expected 1", cpu_hold); end
    if (load_done !== 1'b0) begin n_fail++; $display("FAIL midreset load_done: got %b expected 0", load_done); end
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL midreset load_err: got %b expected 0", load_err); end
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b0;
    cap_a.delete();
    cap_d.delete();
    fill_data(2);
    send_frame(2, good_csum(), 1, 1'b0);
    model_frame(2, good_csum());
    n_checks++;
    if (cap_a.size() != exp_a.size()) begin
      n_fail++; $display("FAIL midreset reload count: got %0d expected %0d", cap_a.size(), exp_a.size());
    end
    foreach (exp_a[i]) if (i < cap_a.size()) begin
      n_checks++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL midreset reload %0d: got %h/%h expected %h/%h", i, cap_a[i], cap_d[i], exp_a[i], exp_d[i]);
      end
    end
    n_checks++;
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL midreset load_done: got %b expected 1", load_done); end
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 8; k++) begin
      int n;
      int r;
      logic [7:0] csum;
      do_reset();
      r = int'($urandom_range(9, 0));
      n = (r == 9) ? MW + 1 + int'($urandom_range(100, 0)) : r;
      fill_data((n > MW) ? 0 : n);
      csum = good_csum();
      if ($urandom_range(2, 0) == 0) csum = csum ^ 8'($urandom_range(255, 1));
      send_frame(n, csum, 3, n > MW);
      model_frame(n, csum);
      n_checks++;
      if (cap_a.size() != exp_a.size()) begin
        n_fail++; $display("FAIL random %0d write count: got %0d expected %0d", k, cap_a.size(), exp_a.size());
      end
      foreach (exp_a[i]) if (i < cap_a.size()) begin
        n_checks++;
        if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL random %0d write %0d: got %h/%h expected %h/%h", k, i, cap_a[i], cap_d[i],
                   exp_a[i], exp_d[i]);
        end
      end
      n_checks += 3;
      if (load_done !== exp_done) begin n_fail++; $display("FAIL random %0d load_done: got %b expected %b", k, load_done, exp_done); end
      if (load_err !== exp_err) begin n_fail++; $display("FAIL random %0d load_err: got %b expected %b", k, load_err, exp_err); end
      if (cpu_hold !== !exp_done) begin n_fail++; $display("FAIL random %0d cpu_hold: got %b expected %b", k, cpu_hold, !exp_done); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_too_long();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
